// File: rtl/apb_pkg.sv
// Shared APB definitions: master FSM state encoding, slave register map, default bus widths.
package apb_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        ACCESS = 2'd2,
        RESP   = 2'd3
    } apb_mst_state_t;

    // Register offsets of the APB-to-I2C slave block.
    localparam logic [7:0] TX_FIFO = 8'd0;
    localparam logic [7:0] RX_FIFO = 8'd4;
    localparam logic [7:0] CONFIG  = 8'd8;
    localparam logic [7:0] TIMEOUT = 8'd12;

    localparam int DEFAULT_ADDR_W = 32;
    localparam int DEFAULT_DATA_W = 32;

endpackage

// File: rtl/apb_wait_timer.sv
// Counts wait-state ACCESS cycles and flags the last one allowed before a transfer is aborted.
// TIMEOUT_CYCLES = 0 removes the counter and never expires.
module apb_wait_timer #(
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    localparam int CNT_W = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;

    generate
        if (TIMEOUT_CYCLES > 0) begin : g_timer
            localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(TIMEOUT_CYCLES);
            localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

            logic [CNT_W-1:0] cnt_q;
            logic [CNT_W-1:0] cnt_d;

            // Next count: clear wins, otherwise count waiting cycles and saturate at the limit.
            always_comb begin
                cnt_d = cnt_q;
                if (clear) begin
                    cnt_d = '0;
                end else if (enable && (cnt_q != CNT_MAX)) begin
                    cnt_d = cnt_q + 1'b1;
                end
            end

            // Counter register.
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    cnt_q <= '0;
                end else begin
                    cnt_q <= cnt_d;
                end
            end

            // The current waiting cycle is the Nth one: if it ends without PREADY, abort.
            assign expired = enable && (cnt_q == CNT_LAST);
        end else begin : g_no_timer
            logic unused_inputs;
            assign unused_inputs = &{1'b0, clk, rst, clear, enable};
            assign expired       = 1'b0;
        end
    endgenerate

endmodule

// File: rtl/apb_master_bridge.sv
// APB3 initiator: turns single-beat requester commands into SETUP/ACCESS transfers and
// returns read data, slave error and timeout status through a valid/ready response port.
module apb_master_bridge
    import apb_pkg::*;
#(
    parameter int ADDR_W         = DEFAULT_ADDR_W,
    parameter int DATA_W         = DEFAULT_DATA_W,
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic              PCLK,
    input  logic              PRESET,
    input  logic              CMD_VALID,
    output logic              CMD_READY,
    input  logic              CMD_WRITE,
    input  logic [ADDR_W-1:0] CMD_ADDR,
    input  logic [DATA_W-1:0] CMD_WDATA,
    output logic              RSP_VALID,
    input  logic              RSP_READY,
    output logic [DATA_W-1:0] RSP_RDATA,
    output logic              RSP_ERR,
    output logic              RSP_TIMEOUT,
    output logic              BUSY,
    output logic              PSELx,
    output logic              PENABLE,
    output logic              PWRITE,
    output logic [ADDR_W-1:0] PADDR,
    output logic [DATA_W-1:0] PWDATA,
    input  logic [DATA_W-1:0] PRDATA,
    input  logic              PREADY,
    input  logic              PSLVERR
);

    apb_mst_state_t    state_q, state_d;
    logic              psel_q, psel_d;
    logic              penable_q, penable_d;
    logic              pwrite_q, pwrite_d;
    logic [ADDR_W-1:0] paddr_q, paddr_d;
    logic [DATA_W-1:0] pwdata_q, pwdata_d;
    logic              rsp_valid_q, rsp_valid_d;
    logic [DATA_W-1:0] rsp_rdata_q, rsp_rdata_d;
    logic              rsp_err_q, rsp_err_d;
    logic              rsp_timeout_q, rsp_timeout_d;

    logic timer_clear;
    logic timer_enable;
    logic timer_expired;

    assign timer_enable = (state_q == ACCESS) && !PREADY;
    assign timer_clear  = (state_q == RESP) && RSP_READY;

    apb_wait_timer #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_wait_timer (
        .clk    (PCLK),
        .rst    (PRESET),
        .clear  (timer_clear),
        .enable (timer_enable),
        .expired(timer_expired)
    );

    // FSM next-state and next-value logic for the APB outputs and response fields.
    always_comb begin
        // NOTE: every _d starts from its _q so no path leaves a signal unassigned (no latches).
        state_d       = state_q;
        psel_d        = psel_q;
        penable_d     = penable_q;
        pwrite_d      = pwrite_q;
        paddr_d       = paddr_q;
        pwdata_d      = pwdata_q;
        rsp_valid_d   = rsp_valid_q;
        rsp_rdata_d   = rsp_rdata_q;
        rsp_err_d     = rsp_err_q;
        rsp_timeout_d = rsp_timeout_q;

        unique case (state_q)
            IDLE: begin
                if (CMD_VALID) begin
                    pwrite_d  = CMD_WRITE;
                    paddr_d   = CMD_ADDR;
                    pwdata_d  = CMD_WRITE ? CMD_WDATA : '0;
                    psel_d    = 1'b1;
                    penable_d = 1'b0;
                    state_d   = SETUP;
                end
            end
            SETUP: begin
                penable_d = 1'b1;
                state_d   = ACCESS;
            end
            ACCESS: begin
                if (PREADY) begin
                    rsp_rdata_d   = pwrite_q ? '0 : PRDATA;
                    rsp_err_d     = PSLVERR;
                    rsp_timeout_d = 1'b0;
                    psel_d        = 1'b0;
                    penable_d     = 1'b0;
                    rsp_valid_d   = 1'b1;
                    state_d       = RESP;
                end else if (timer_expired) begin
                    rsp_rdata_d   = '0;
                    rsp_err_d     = 1'b1;
                    rsp_timeout_d = 1'b1;
                    psel_d        = 1'b0;
                    penable_d     = 1'b0;
                    rsp_valid_d   = 1'b1;
                    state_d       = RESP;
                end
            end
            RESP: begin
                if (RSP_READY) begin
                    rsp_valid_d = 1'b0;
                    state_d     = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State and output registers; reset aborts any transfer without producing a response.
    always_ff @(posedge PCLK or posedge PRESET) begin
        if (PRESET) begin
            state_q       <= IDLE;
            psel_q        <= 1'b0;
            penable_q     <= 1'b0;
            pwrite_q      <= 1'b0;
            paddr_q       <= '0;
            pwdata_q      <= '0;
            rsp_valid_q   <= 1'b0;
            rsp_rdata_q   <= '0;
            rsp_err_q     <= 1'b0;
            rsp_timeout_q <= 1'b0;
        end else begin
            // NOTE: non-blocking so every flop updates from the same pre-edge values.
            state_q       <= state_d;
            psel_q        <= psel_d;
            penable_q     <= penable_d;
            pwrite_q      <= pwrite_d;
            paddr_q       <= paddr_d;
            pwdata_q      <= pwdata_d;
            rsp_valid_q   <= rsp_valid_d;
            rsp_rdata_q   <= rsp_rdata_d;
            rsp_err_q     <= rsp_err_d;
            rsp_timeout_q <= rsp_timeout_d;
        end
    end

    assign CMD_READY   = (state_q == IDLE);
    assign BUSY        = (state_q != IDLE);
    assign PSELx       = psel_q;
    assign PENABLE     = penable_q;
    assign PWRITE      = pwrite_q;
    assign PADDR       = paddr_q;
    assign PWDATA      = pwdata_q;
    assign RSP_VALID   = rsp_valid_q;
    assign RSP_RDATA   = rsp_rdata_q;
    assign RSP_ERR     = rsp_err_q;
    assign RSP_TIMEOUT = rsp_timeout_q;

endmodule

// File: tb/tb_apb_master_bridge.sv
// Self-checking bench for apb_master_bridge: scripted commands against a small APB slave model,
// expected responses queued at command time and compared when the bridge hands them back.
module tb_apb_master_bridge;
    import apb_pkg::*;

    localparam int AW = 32;
    localparam int DW = 32;

    logic          PCLK = 1'b0;
    logic          PRESET;
    logic          CMD_VALID, CMD_READY, CMD_WRITE;
    logic [AW-1:0] CMD_ADDR;
    logic [DW-1:0] CMD_WDATA;
    logic          RSP_VALID, RSP_READY;
    logic [DW-1:0] RSP_RDATA;
    logic          RSP_ERR, RSP_TIMEOUT, BUSY;
    logic          PSELx, PENABLE, PWRITE;
    logic [AW-1:0] PADDR;
    logic [DW-1:0] PWDATA, PRDATA;
    logic          PREADY, PSLVERR;

    typedef struct packed {
        logic [DW-1:0] rdata;
        logic          err;
        logic          timeout;
    } rsp_t;

    rsp_t exp_q[$];
    int   n_vec = 0;
    int   n_miscompare = 0;

    // Slave model controls and state
    int            slv_wait  = 0;
    logic [DW-1:0] slv_rdata = '0;
    logic          slv_err   = 1'b0;
    int            acc_cnt   = 0;
    logic [DW-1:0] slv_mem [4];
    logic [AW-1:0] setup_addr;
    logic [DW-1:0] setup_wdata;
    logic          setup_write;

    apb_master_bridge #(
        .ADDR_W(AW), .DATA_W(DW), .TIMEOUT_CYCLES(16)
    ) dut (
        .PCLK(PCLK), .PRESET(PRESET),
        .CMD_VALID(CMD_VALID), .CMD_READY(CMD_READY), .CMD_WRITE(CMD_WRITE),
        .CMD_ADDR(CMD_ADDR), .CMD_WDATA(CMD_WDATA),
        .RSP_VALID(RSP_VALID), .RSP_READY(RSP_READY), .RSP_RDATA(RSP_RDATA),
        .RSP_ERR(RSP_ERR), .RSP_TIMEOUT(RSP_TIMEOUT), .BUSY(BUSY),
        .PSELx(PSELx), .PENABLE(PENABLE), .PWRITE(PWRITE), .PADDR(PADDR),
        .PWDATA(PWDATA), .PRDATA(PRDATA), .PREADY(PREADY), .PSLVERR(PSLVERR)
    );

    always #5 PCLK = ~PCLK;

    // Slave: ready after slv_wait waiting ACCESS cycles; data/error lines carry junk until then.
    assign PREADY  = PSELx && PENABLE && (acc_cnt == slv_wait);
    assign PRDATA  = PREADY ? slv_rdata : 32'hBAD0_0BAD;
    assign PSLVERR = PREADY ? slv_err : 1'b1;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_miscompare++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Slave wait counter and register file write on successful completion.
    always @(posedge PCLK) begin
        acc_cnt <= (PSELx && PENABLE && !PREADY) ? acc_cnt + 1 : 0;
        if (PSELx && PENABLE && PREADY && PWRITE && !slv_err)
            slv_mem[PADDR[3:2]] <= PWDATA;
    end

    // Protocol monitor: address/direction/data must not move between SETUP and end of ACCESS.
    always @(negedge PCLK) begin
        if (!PRESET && PSELx && !PENABLE) begin
            setup_addr  = PADDR;
            setup_wdata = PWDATA;
            setup_write = PWRITE;
        end else if (!PRESET && PSELx && PENABLE) begin
            check("apb_stable", {PADDR, PWDATA}, {setup_addr, setup_wdata});
            check("apb_dir_stable", PWRITE, setup_write);
        end
    end

    // Response scoreboard: compare each consumed response with the oldest expectation.
    always @(negedge PCLK) begin
        if (!PRESET && RSP_VALID && RSP_READY) begin
            if (exp_q.size() == 0) begin
                check("rsp_unexpected", 1, 0);
            end else begin
                rsp_t e;
                e = exp_q.pop_front();
                check("rsp_fields", {RSP_RDATA, RSP_ERR, RSP_TIMEOUT}, e);
            end
        end
    end

    task automatic step();
        @(posedge PCLK);
        #1;
    endtask

    // Present a command, wait (bounded) for acceptance, queue its expected response.
    // Returns one cycle after acceptance, i.e. in the SETUP cycle.
    task automatic send_cmd(input logic wr, input logic [AW-1:0] addr, input logic [DW-1:0] wdata,
                            input rsp_t exp);
        int n = 0;
        CMD_VALID = 1'b1; CMD_WRITE = wr; CMD_ADDR = addr; CMD_WDATA = wdata;
        while (!CMD_READY && n < 100) begin
            step();
            n++;
        end
        if (!CMD_READY) check("cmd_accept_timeout", 0, 1);
        exp_q.push_back(exp);
        step();
        CMD_VALID = 1'b0;
    endtask

    task automatic wait_rsp();
        int n = 0;
        while (!RSP_VALID && n < 64) begin
            step();
            n++;
        end
        if (!RSP_VALID) check("rsp_wait_timeout", 0, 1);
    endtask

    // Walk through ACCESS cycles from a SETUP cycle; returns how many ACCESS cycles were seen.
    task automatic count_access(input logic [AW-1:0] addr, output int n);
        n = 0;
        step();
        while (PENABLE && n < 40) begin
            check("access_paddr", PADDR, addr);
            n++;
            step();
        end
    endtask

    initial begin
        int n;
        rsp_t r;
        for (int i = 0; i < 4; i++) slv_mem[i] = '0;
        PRESET = 1'b1; CMD_VALID = 1'b0; CMD_WRITE = 1'b0; CMD_ADDR = '0; CMD_WDATA = '0;
        RSP_READY = 1'b1;
        #1;
        check("reset_outputs", {PSELx, PENABLE, PWRITE, RSP_VALID, RSP_ERR, RSP_TIMEOUT, BUSY},
              7'b0);
        check("reset_paddr_pwdata", {PADDR, PWDATA}, 64'h0);
        check("reset_rdata", RSP_RDATA, 0);
        check("reset_cmd_ready", CMD_READY, 1);
        step(); step();
        PRESET = 1'b0;
        step();

        // 1. Zero-wait write to CONFIG
        slv_wait = 0; slv_err = 1'b0;
        r = '{rdata: '0, err: 1'b0, timeout: 1'b0};
        send_cmd(1'b1, 32'(CONFIG), 32'h1A5, r);
        check("wr_setup", {PSELx, PENABLE, BUSY, CMD_READY}, 4'b1010);
        step();
        check("wr_access", {PSELx, PENABLE}, 2'b11);
        step();
        check("wr_rsp_cycle3", {RSP_VALID, RSP_ERR, PSELx, PENABLE}, 4'b1000);
        step();
        check("wr_back_idle", {BUSY, CMD_READY, RSP_VALID}, 3'b010);
        check("wr_hold_paddr", PADDR, 32'h8);
        check("slave_config", slv_mem[2], 32'h1A5);

        // 2. Read RX_FIFO with 3 wait states
        slv_wait = 3; slv_rdata = 32'hDEADBEEF;
        r = '{rdata: 32'hDEADBEEF, err: 1'b0, timeout: 1'b0};
        send_cmd(1'b0, 32'(RX_FIFO), 32'hFFFF_FFFF, r);
        check("rd_pwdata_zero", PWDATA, 0);
        count_access(32'h4, n);
        check("rd_access_cycles", n, 4);
        check("rd_rsp", {RSP_VALID, RSP_RDATA}, {1'b1, 32'hDEADBEEF});
        step();

        // 3. Slave error on write to TX_FIFO
        slv_wait = 0; slv_err = 1'b1; slv_rdata = 32'h1234_5678;
        r = '{rdata: '0, err: 1'b1, timeout: 1'b0};
        send_cmd(1'b1, 32'(TX_FIFO), 32'h3C, r);
        wait_rsp();
        check("err_rsp", {RSP_ERR, RSP_TIMEOUT, RSP_RDATA}, {2'b10, 32'h0});
        step();
        slv_err = 1'b0;

        // 4a. Hung slave -> timeout after 16 ACCESS cycles
        slv_wait = 1000;
        r = '{rdata: '0, err: 1'b1, timeout: 1'b1};
        send_cmd(1'b0, 32'(TIMEOUT), 32'h0, r);
        count_access(32'hC, n);
        check("to_access_cycles", n, 16);
        check("to_rsp", {PSELx, RSP_VALID, RSP_ERR, RSP_TIMEOUT}, 4'b0111);
        step();

        // 4b. PREADY in the 16th ACCESS cycle is a normal completion
        slv_wait = 15; slv_rdata = 32'hCAFE_F00D;
        r = '{rdata: 32'hCAFE_F00D, err: 1'b0, timeout: 1'b0};
        send_cmd(1'b0, 32'(TIMEOUT), 32'h0, r);
        count_access(32'hC, n);
        check("late_ready_cycles", n, 16);
        check("late_ready_rsp", {RSP_VALID, RSP_TIMEOUT, RSP_ERR}, 3'b100);
        step();

        // 5. Response backpressure with a second command queued
        slv_wait = 0; slv_rdata = 32'h55;
        RSP_READY = 1'b0;
        r = '{rdata: 32'h55, err: 1'b0, timeout: 1'b0};
        send_cmd(1'b0, 32'(CONFIG), 32'h0, r);
        wait_rsp();
        CMD_VALID = 1'b1; CMD_WRITE = 1'b1; CMD_ADDR = 32'h0; CMD_WDATA = 32'h77;
        exp_q.push_back('{rdata: '0, err: 1'b0, timeout: 1'b0});
        for (int i = 0; i < 5; i++) begin
            check("bp_hold", {RSP_VALID, CMD_READY, BUSY, RSP_RDATA}, {3'b101, 32'h55});
            step();
        end
        RSP_READY = 1'b1;
        check("bp_release_cmd_ready", CMD_READY, 0);
        step();
        check("bp_idle", {CMD_READY, RSP_VALID, PSELx}, 3'b100);
        step();
        CMD_VALID = 1'b0;
        check("bp_second_setup", {PSELx, PENABLE, PADDR}, {2'b10, 32'h0});
        wait_rsp();
        step();
        check("slave_tx_fifo", slv_mem[0], 32'h77);

        // 6. Asynchronous reset in the middle of ACCESS
        slv_wait = 1000;
        send_cmd(1'b0, 32'(RX_FIFO), 32'h0, '{rdata: '0, err: 1'b1, timeout: 1'b1});
        step();
        check("rst_in_access", PENABLE, 1);
        #2 PRESET = 1'b1;
        #1;
        check("rst_async", {PSELx, PENABLE, RSP_VALID, BUSY}, 4'b0000);
        exp_q.delete();
        step();
        PRESET = 1'b0;
        check("rst_cmd_ready", CMD_READY, 1);
        step();
        slv_wait = 0;
        r = '{rdata: '0, err: 1'b0, timeout: 1'b0};
        send_cmd(1'b1, 32'(TIMEOUT), 32'h99, r);
        wait_rsp();
        check("post_rst_rsp", {RSP_VALID, RSP_ERR, RSP_TIMEOUT}, 3'b100);
        step();
        check("slave_timeout_reg", slv_mem[3], 32'h99);

        n = 0;
        while (exp_q.size() != 0 && n < 20) begin
            step();
            n++;
        end
        check("scoreboard_drained", exp_q.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miscompare);
        $finish;
    end

endmodule
